// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared types and widths for the issue/hazard control slice.
package issue_hazard_ctrl_pkg;

    localparam int cXLEN       = 32;
    localparam int cREG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } tCtrlState;

endpackage

// File: rtl/issue_hazard_ctrl_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with a same-cycle writeback bypass on the lookups.
module reg_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [ADDR_W-1:0]  set_addr,
    input  logic               clr_en,
    input  logic [ADDR_W-1:0]  clr_addr,
    input  logic [ADDR_W-1:0]  rs1_addr,
    input  logic [ADDR_W-1:0]  rs2_addr,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [REG_NUM-1:0] busy_mask,
    output logic               busy_rs1,
    output logic               busy_rs2,
    output logic               busy_rd
);

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_eff;
    logic [REG_NUM-1:0] busy_nxt;

    // A retiring write this cycle already frees its register for lookup.
    always_comb begin
        busy_eff = busy;
        if (clr_en) busy_eff[clr_addr] = 1'b0;
        busy_eff[0] = 1'b0;
    end

    // Set is applied after clear so a colliding new writer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en && (set_addr != '0)) busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_mask = busy;
    assign busy_rs1  = busy_eff[rs1_addr];
    assign busy_rs2  = busy_eff[rs2_addr];
    assign busy_rd   = busy_eff[rd_addr];

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue sequencer between decoder and execute: RAW/WAW stalls, branch hold, and decoder flush on taken branches.
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int REG_NUM     = cXLEN,
    parameter int ADDR_W      = cREG_ADDR_W,
    parameter int DEC_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    input  logic [ADDR_W-1:0]  dec_rs1_addr,
    input  logic [ADDR_W-1:0]  dec_rs2_addr,
    input  logic [ADDR_W-1:0]  dec_rd_addr,
    input  logic               dec_use_rs1,
    input  logic               dec_use_rs2,
    input  logic               dec_write_rd,
    input  logic               dec_is_branch,
    input  logic               ex_ready,
    input  logic               wb_valid,
    input  logic [ADDR_W-1:0]  wb_rd_addr,
    input  logic               br_resolved,
    input  logic               br_taken,
    output logic               issue_valid,
    output logic               dec_stall,
    output logic               flush_pipe,
    output logic [REG_NUM-1:0] busy_mask,
    output logic [1:0]         ctrl_state
);

    localparam int CNT_W = $clog2(DEC_LATENCY + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(DEC_LATENCY - 1);

    tCtrlState        state;
    logic [CNT_W-1:0] flush_cnt;
    logic             busy_rs1;
    logic             busy_rs2;
    logic             busy_rd;
    logic             hazard;

    reg_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue_valid & dec_write_rd),
        .set_addr  (dec_rd_addr),
        .clr_en    (wb_valid),
        .clr_addr  (wb_rd_addr),
        .rs1_addr  (dec_rs1_addr),
        .rs2_addr  (dec_rs2_addr),
        .rd_addr   (dec_rd_addr),
        .busy_mask (busy_mask),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .busy_rd   (busy_rd)
    );

    assign hazard = (dec_use_rs1 & busy_rs1) | (dec_use_rs2 & busy_rs2) | (dec_write_rd & busy_rd);

    // Handshake: an instruction transfers when issue_valid is high; dec_stall tells the decoder to hold it.
    always_comb begin
        issue_valid = 1'b0;
        dec_stall   = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    issue_valid = dec_valid & ex_ready & ~hazard;
                    dec_stall   = dec_valid & ~(ex_ready & ~hazard);
                end
                BR_WAIT: dec_stall = dec_valid;
                default: ;
            endcase
        end
    end

    // Counter is loaded with DEC_LATENCY-1 and exit happens on the zero cycle, giving DEC_LATENCY flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_cnt  <= '0;
            flush_pipe <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (issue_valid && dec_is_branch) state <= BR_WAIT;
                end
                BR_WAIT: begin
                    if (br_resolved) begin
                        if (br_taken) begin
                            state      <= FLUSH;
                            flush_cnt  <= FLUSH_LOAD;
                            flush_pipe <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state      <= RUN;
                        flush_pipe <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= RUN;
                    flush_pipe <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Randomized bench for issue_hazard_ctrl with a per-cycle reference model and an expected-output queue.
module tb_issue_hazard_ctrl;

    localparam int REG_NUM     = 32;
    localparam int ADDR_W      = 5;
    localparam int DEC_LATENCY = 2;
    localparam int EXP_W       = 3 + REG_NUM + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              dec_valid;
    logic [ADDR_W-1:0] dec_rs1_addr;
    logic [ADDR_W-1:0] dec_rs2_addr;
    logic [ADDR_W-1:0] dec_rd_addr;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic              dec_write_rd;
    logic              dec_is_branch;
    logic              ex_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic              br_resolved;
    logic              br_taken;
    logic              issue_valid;
    logic              dec_stall;
    logic              flush_pipe;
    logic [REG_NUM-1:0] busy_mask;
    logic [1:0]        ctrl_state;

    issue_hazard_ctrl #(
        .REG_NUM     (REG_NUM),
        .ADDR_W      (ADDR_W),
        .DEC_LATENCY (DEC_LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid     (dec_valid),
        .dec_rs1_addr  (dec_rs1_addr),
        .dec_rs2_addr  (dec_rs2_addr),
        .dec_rd_addr   (dec_rd_addr),
        .dec_use_rs1   (dec_use_rs1),
        .dec_use_rs2   (dec_use_rs2),
        .dec_write_rd  (dec_write_rd),
        .dec_is_branch (dec_is_branch),
        .ex_ready      (ex_ready),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .br_resolved   (br_resolved),
        .br_taken      (br_taken),
        .issue_valid   (issue_valid),
        .dec_stall     (dec_stall),
        .flush_pipe    (flush_pipe),
        .busy_mask     (busy_mask),
        .ctrl_state    (ctrl_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: mode 0 = issuing, 1 = waiting on branch, 2 = flushing
    logic [REG_NUM-1:0] m_busy;
    int                 m_mode;
    int                 m_flush_left;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    bit drive_done = 1'b0;

    function automatic bit pending(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if (wb_valid && wb_rd_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    // Compute this cycle's expected outputs from the model, queue them, then advance the model.
    task automatic model_step();
        bit iv, st, fp, hz;
        logic [1:0] cs;
        fp = (m_mode == 2);
        cs = 2'(m_mode);
        iv = 1'b0;
        st = 1'b0;
        hz = (dec_use_rs1 && pending(dec_rs1_addr)) || (dec_use_rs2 && pending(dec_rs2_addr)) ||
             (dec_write_rd && pending(dec_rd_addr));
        if (!rst) begin
            if (m_mode == 0) begin
                iv = dec_valid && ex_ready && !hz;
                st = dec_valid && !iv;
            end else if (m_mode == 1) begin
                st = dec_valid;
            end
        end
        exp_q.push_back({iv, st, fp, m_busy, cs});
        if (rst) begin
            m_busy = '0;
            m_mode = 0;
            m_flush_left = 0;
        end else begin
            if (wb_valid) m_busy[wb_rd_addr] = 1'b0;
            if (iv && dec_write_rd && dec_rd_addr != 0) m_busy[dec_rd_addr] = 1'b1;
            if (m_mode == 0) begin
                if (iv && dec_is_branch) m_mode = 1;
            end else if (m_mode == 1) begin
                if (br_resolved && br_taken) begin
                    m_mode = 2;
                    m_flush_left = DEC_LATENCY;
                end else if (br_resolved) begin
                    m_mode = 0;
                end
            end else begin
                m_flush_left--;
                if (m_flush_left == 0) m_mode = 0;
            end
        end
    endtask

    // driver: one call per cycle, inputs change 1 time unit after the rising edge
    task automatic cyc(input bit r, input bit dv, input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit wr, input bit br, input bit exr,
                       input bit wbv, input int wba, input bit brr, input bit brt);
        @(posedge clk);
        #1;
        rst = r; dec_valid = dv;
        dec_rs1_addr = ADDR_W'(rs1); dec_rs2_addr = ADDR_W'(rs2); dec_rd_addr = ADDR_W'(rd);
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_write_rd = wr; dec_is_branch = br;
        ex_ready = exr; wb_valid = wbv; wb_rd_addr = ADDR_W'(wba);
        br_resolved = brr; br_taken = brt;
        model_step();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input logic [REG_NUM-1:0] act, input logic [REG_NUM-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle_no, act, req);
        end
    endtask

    // monitor: outputs are presented every cycle; compare mid-cycle against the queue head
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("issue_valid", REG_NUM'(issue_valid), REG_NUM'(e[EXP_W-1]));
                check("dec_stall",   REG_NUM'(dec_stall),   REG_NUM'(e[EXP_W-2]));
                check("flush_pipe",  REG_NUM'(flush_pipe),  REG_NUM'(e[EXP_W-3]));
                check("busy_mask",   busy_mask,             e[REG_NUM+1:2]);
                check("ctrl_state",  REG_NUM'(ctrl_state),  REG_NUM'(e[1:0]));
            end
        end
    end

    initial begin
        rst = 1'b1; dec_valid = 0; dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rd_addr = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_write_rd = 0; dec_is_branch = 0; ex_ready = 1;
        wb_valid = 0; wb_rd_addr = 0; br_resolved = 0; br_taken = 0;
        @(posedge clk);
        #1;
        m_busy = '0; m_mode = 0; m_flush_left = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();

        // RAW on x5, released by a same-cycle writeback
        cyc(0, 1, 0, 0, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 5, 1, 6, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 5, 1, 6, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 5, 1, 6, 1, 1, 1, 0, 1, 1, 5, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0);
        // writes to x0 never become pending
        cyc(0, 1, 1, 2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 3, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0);
        // not-taken branch resolved three cycles after issue
        cyc(0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 4, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 4, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 4, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        cyc(0, 1, 2, 0, 4, 1, 0, 1, 0, 1, 1, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0);
        // taken branch: two flush cycles then back to issuing
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 9, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 9, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 9, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0);
        // collision on x7: set wins over writeback
        cyc(0, 1, 0, 0, 7, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 7, 0, 0, 1, 0, 1, 1, 7, 0, 0);
        // reset in the middle of a flush with x5 and x7 pending
        cyc(0, 1, 0, 0, 5, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();
        idle();

        // randomized traffic with addresses packed into x0..x7 to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 85,
                $urandom_range(0, 99) < 35, int'($urandom_range(0, 7)),
                $urandom_range(0, 99) < 30, $urandom_range(0, 1) == 1);
        end
        idle();
        drive_done = 1'b1;

        // report
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
- Sequences the output of the instruction decoder into the execute stage.
- Keeps a per-register pending-write scoreboard and stalls the decoder on RAW/WAW hazards.
- Holds issue while a branch is unresolved. On a taken branch it drives the decoder flush for the decoder pipeline depth.
- Sits between instDecoder and the execute/branch units; its flush_pipe output drives the decoder's flush input.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero).
- ADDR_W, 5, register address width; equals log2(REG_NUM).
- DEC_LATENCY, 2, decoder pipeline depth in cycles; equals the flush hold length.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dec_valid  in  1  decoder presents a valid instruction
- dec_rs1_addr  in  ADDR_W  source 1 address
- dec_rs2_addr  in  ADDR_W  source 2 address
- dec_rd_addr  in  ADDR_W  destination address
- dec_use_rs1  in  1  instruction reads rs1
- dec_use_rs2  in  1  instruction reads rs2
- dec_write_rd  in  1  instruction writes rd
- dec_is_branch  in  1  branch/jump instruction
- ex_ready  in  1  execute stage can accept an instruction
- wb_valid  in  1  writeback retiring a register write
- wb_rd_addr  in  ADDR_W  retiring destination
- br_resolved  in  1  branch unit result valid
- br_taken  in  1  resolved branch redirects PC (qualified by br_resolved)
- issue_valid  out  1  instruction accepted into execute this cycle
- dec_stall  out  1  decoder must hold its current instruction
- flush_pipe  out  1  flush decoder pipeline
- busy_mask  out  REG_NUM  scoreboard state, bit i = write to xi pending
- ctrl_state  out  2  current FSM state, for debug

Behaviour:
- Reset:
  - state RUN; scoreboard all 0; flush counter 0; flush_pipe 0.
  - issue_valid 0 and dec_stall 0 (both gated by rst).
- Effective busy:
  - busy_eff[i] = busy[i] & ~(wb_valid & wb_rd_addr==i); a same-cycle writeback is a bypass.
  - busy_eff[0] is always 0.
- Hazard:
  - hazard = (dec_use_rs1 & busy_eff[rs1]) | (dec_use_rs2 & busy_eff[rs2]) | (dec_write_rd & busy_eff[rd]).
- States:
  - RUN: issue_valid = dec_valid & ex_ready & ~hazard (combinational). dec_stall = dec_valid & ~issue_valid.
  - RUN: issue of dec_is_branch goes to BR_WAIT next cycle. br_resolved is ignored in RUN.
  - BR_WAIT: issue_valid 0; dec_stall = dec_valid. On br_resolved & ~br_taken, go to RUN. On br_resolved & br_taken, go to FLUSH and load the counter with DEC_LATENCY-1. No issue in the resolution cycle.
  - FLUSH: flush_pipe 1 (registered from state); issue_valid 0; dec_stall 0. The counter decrements and the FSM returns to RUN when it reaches 0. A taken branch resolved at edge T gives flush_pipe high for exactly DEC_LATENCY cycles, T+1..T+DEC_LATENCY.
- Scoreboard update at posedge:
  - Clear busy[wb_rd_addr] on wb_valid.
  - Set busy[dec_rd_addr] on issue_valid & dec_write_rd & rd!=0.
  - Set wins on a same-address collision.
  - Writeback to a non-busy register or to x0 has no effect.
- Flush does not alter the scoreboard; older issued instructions still retire.
- Reset mid-BR_WAIT/FLUSH returns to RUN in the next cycle with the scoreboard cleared and flush_pipe deasserted.
- busy_mask is the registered scoreboard, without the bypass.

Decomposition:
- Shared package: tCtrlState enum {RUN=2'd0, BR_WAIT=2'd1, FLUSH=2'd2}; register address width constant alongside cXLEN.
- One sub-module, reg_scoreboard: REG_NUM-bit set/clear register with a bypassed busy_eff lookup for three read addresses.

Test Plan:
- Issue add x5 (write_rd, rd=5), then next cycle add x6,x5,x1 with wb idle → second instruction stalls: dec_stall=1, issue_valid=0. wb_valid with wb_rd_addr=5 → issues that same cycle and busy_mask[5] returns to 0.
- Instruction with rd=0 and write_rd=1 issued → busy_mask stays 0. Following reader of x0 issues without stall.
- Branch issued, then br_resolved=1, br_taken=0 three cycles later → dec_stall high while in BR_WAIT. Issue resumes the cycle after resolution; flush_pipe never asserts.
- Branch taken with DEC_LATENCY=2 → flush_pipe high exactly 2 cycles, issue_valid 0 and dec_stall 0 during them, back in RUN on the third cycle.
- Same-cycle wb_valid rd=7 and issue writing rd=7 → busy_mask[7]=1 afterwards (set wins).
- rst asserted during FLUSH with busy_mask=0x0000_00A0 → next cycle ctrl_state=RUN, flush_pipe=0, busy_mask=0.
